// File: rtl/apb_regfile_slave.sv
// APB register bank with a read-only {wr_cnt, rd_cnt} status register in the top slot.
// PREADY rises WAIT_CYCLES cycles after the first ACCESS cycle; the bridge is stalled until then.
module apb_regfile_slave #(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        PCLK,
    input  logic        PRST,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [5:0]  r_idx;
    logic        r_write;
    logic        r_err;
    logic [31:0] r_wdata;
    logic [3:0]  r_wait;
    logic        r_pready;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;
    logic [31:0] r_regs [NUM_REGS-1];

    logic        w_setup;
    logic        w_count;
    logic        w_commit;
    logic [5:0]  w_idx;
    logic        w_err_in;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_idx         = PADDR[7:2];
    assign w_unused_addr = ^PADDR[31:8];

    // Status slot is read-only, so a write to it is flagged like a bad address.
    assign w_err_in = (PADDR[1:0] != 2'b00)
                   || ({1'b0, w_idx} >= 7'(NUM_REGS))
                   || (PWRITE && ({1'b0, w_idx} == 7'(NUM_REGS - 1)));

    always_comb begin
        w_next   = r_state;
        w_setup  = 1'b0;
        w_count  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSELx && !PENABLE) begin
                    w_setup = 1'b1;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSELx) begin
                    w_next = ST_IDLE;
                end else if (PENABLE) begin
                    if (r_pready) begin
                        w_commit = 1'b1;
                        w_next   = ST_DONE;
                    end else begin
                        w_count = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (PSELx && !PENABLE) begin
                    w_setup = 1'b1;
                    w_next  = ST_ACCESS;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_wait   <= '0;
            r_pready <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_next;

            // PREADY is registered, so with no wait states it must be set at the setup edge.
            if (w_setup) begin
                r_idx    <= w_idx;
                r_write  <= PWRITE;
                r_err    <= w_err_in;
                r_wdata  <= PWDATA;
                r_wait   <= 4'(WAIT_CYCLES);
                r_pready <= (WAIT_CYCLES == 0);
            end else if (w_count) begin
                r_wait   <= r_wait - 4'd1;
                r_pready <= (r_wait == 4'd1);
            end else if (w_next != ST_ACCESS) begin
                r_pready <= 1'b0;
            end

            if (w_commit && !r_err) begin
                if (r_write) begin
                    r_wr_cnt <= r_wr_cnt + 16'd1;
                    for (int i = 0; i < NUM_REGS - 1; i++) begin
                        if (r_idx == 6'(i)) begin
                            r_regs[i] <= r_wdata;
                        end
                    end
                end else begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_idx == 6'(NUM_REGS - 1)) begin
            w_rdata = {r_wr_cnt, r_rd_cnt};
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (r_idx == 6'(i)) begin
                    w_rdata = r_regs[i];
                end
            end
        end
    end

    // Status read returns the pre-increment count; rd_cnt only bumps at the closing edge.
    assign PREADY  = r_pready;
    assign PSLVERR = r_pready & r_err;
    assign PRDATA  = (r_pready && !r_err && !r_write) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: instance 0 runs with one wait state, instance 1 with none.
module tb_apb_regfile_slave;

    logic        clk = 1'b0;
    logic        prst    [2];
    logic        psel    [2];
    logic        pen     [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(1)) u_dut_w1 (
        .PCLK(clk), .PRST(prst[0]), .PSELx(psel[0]), .PENABLE(pen[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .PCLK(clk), .PRST(prst[1]), .PSELx(psel[1]), .PENABLE(pen[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int lat);
        @(posedge clk); #1;
        psel[d] = 1'b1; pen[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
        @(posedge clk); #1;
        pen[d] = 1'b1;
        lat = -1; rdata = '0; err = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pready[d]) begin
                lat = n; rdata = prdata[d]; err = pslverr[d];
                break;
            end
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; pen[d] = 1'b0;
        @(negedge clk);
        check("pready_one_cycle", 32'(pready[d]), 32'd0);
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        apb_xfer(d, 1'b1, addr, data, rd, er, lat);
        check("wr_latency", lat, exp_lat);
        check("wr_slverr", 32'(er), 32'(exp_err));
        check("wr_prdata", rd, 32'd0);
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        apb_xfer(d, 1'b0, addr, 32'd0, rd, er, lat);
        check("rd_latency", lat, exp_lat);
        check("rd_slverr", 32'(er), 32'(exp_err));
        check("rd_data", rd, exp_data);
    endtask

    task automatic do_reset(input int d);
        @(posedge clk); #1;
        prst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1 prst[d] = 1'b0;
    endtask

    int t1;
    int t2;

    initial begin
        for (int d = 0; d < 2; d++) begin
            prst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_pready", 32'(pready[d]), 32'd0);
            check("rst_pslverr", 32'(pslverr[d]), 32'd0);
            check("rst_prdata", prdata[d], 32'd0);
        end
        @(posedge clk); #1;
        prst[0] = 1'b0; prst[1] = 1'b0;

        // One wait state: PREADY lands in T2
        do_read(0, 32'h0C, 32'd0, 1'b0, 1);
        do_reset(0);

        do_write(0, 32'h08, 32'hDEADBEEF, 1'b0, 1);
        do_read(0, 32'h08, 32'hDEADBEEF, 1'b0, 1);
        do_read(0, 32'h3C, 32'h0001_0001, 1'b0, 1);

        do_write(0, 32'h3C, 32'h1111_1111, 1'b1, 1);
        do_write(0, 32'h40, 32'h2222_2222, 1'b1, 1);
        do_read(0, 32'h0A, 32'd0, 1'b1, 1);
        do_read(0, 32'h08, 32'hDEADBEEF, 1'b0, 1);
        do_read(0, 32'h3C, 32'h0001_0003, 1'b0, 1);

        do_write(0, 32'h38, 32'hCAFEF00D, 1'b0, 1);
        do_read(0, 32'h38, 32'hCAFEF00D, 1'b0, 1);

        // PSELx dropped in the first ACCESS cycle
        @(posedge clk); #1;
        psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h04; pwdata[0] = 32'h55;
        @(posedge clk); #1;
        psel[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_pready", 32'(pready[0]), 32'd0);
        end
        do_read(0, 32'h04, 32'd0, 1'b0, 1);
        do_read(0, 32'h3C, 32'h0002_0006, 1'b0, 1);

        // Reset during the wait state of a write
        @(posedge clk); #1;
        psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0C; pwdata[0] = 32'h1234;
        @(posedge clk); #1;
        pen[0] = 1'b1; prst[0] = 1'b1;
        @(posedge clk); #1;
        psel[0] = 1'b0; pen[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_pready", 32'(pready[0]), 32'd0);
        @(posedge clk); #1;
        prst[0] = 1'b0;
        do_read(0, 32'h3C, 32'd0, 1'b0, 1);
        do_read(0, 32'h0C, 32'd0, 1'b0, 1);
        do_read(0, 32'h08, 32'd0, 1'b0, 1);

        // Zero wait states, back-to-back setup in the DONE cycle
        @(posedge clk); #1;
        psel[1] = 1'b1; pen[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h00; pwdata[1] = 32'h11;
        @(posedge clk); #1;
        pen[1] = 1'b1;
        @(negedge clk);
        check("b2b_first_pready", 32'(pready[1]), 32'd1);
        t1 = cyc;
        @(posedge clk); #1;
        pen[1] = 1'b0; pwrite[1] = 1'b0;
        @(negedge clk);
        check("b2b_done_gap", 32'(pready[1]), 32'd0);
        @(posedge clk); #1;
        pen[1] = 1'b1;
        @(negedge clk);
        t2 = cyc;
        check("b2b_second_pready", 32'(pready[1]), 32'd1);
        check("b2b_spacing", t2 - t1, 32'd2);
        check("b2b_rdata", prdata[1], 32'h11);
        check("b2b_slverr", 32'(pslverr[1]), 32'd0);
        @(posedge clk); #1;
        psel[1] = 1'b0; pen[1] = 1'b0;
        do_read(1, 32'h3C, 32'h0001_0001, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
